// File: rtl/led_seq_pkg.sv
// Shared mode encoding and per-mode seed values for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_FILL  = 2'd3
    } mode_t;

    // Seeds are either all-zero or a single lit bit0, so one bit describes each.
    localparam logic SEED_COUNT = 1'b0;
    localparam logic SEED_SHIFT = 1'b1;
    localparam logic SEED_SCAN  = 1'b1;
    localparam logic SEED_FILL  = 1'b0;

    function automatic logic seed_lsb(input mode_t m);
        logic s;
        unique case (m)
            MODE_COUNT: s = SEED_COUNT;
            MODE_SHIFT: s = SEED_SHIFT;
            MODE_SCAN:  s = SEED_SCAN;
            MODE_FILL:  s = SEED_FILL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-tick prescaler: counts 0..PRESCALE-1 while running, tick on wrap.
module led_prescaler #(
    parameter int PRESCALE = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: COUNT/SHIFT/SCAN/FILL modes, button-cycled mode.
// Define DEBOUNCE_EN to insert a debouncer (DEBOUNCE_CYC) on the button.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W    = 6,
    parameter int PRESCALE = 1048576
`ifdef DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYC = 270000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic             mode_btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             step
);

    localparam logic [LED_W-1:0] ONE = LED_W'(1);
    localparam logic [LED_W-1:0] MSB = ONE << (LED_W - 1);

    logic sync1_q, sync2_q, prev_q;
    logic btn_lvl, mode_adv, tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= mode_btn;
            sync2_q <= sync1_q;
            prev_q  <= btn_lvl;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_q, deb_d;

    // Any cycle where the input agrees with the held level restarts the count.
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
        end
    end

    assign btn_lvl = deb_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign mode_adv = btn_lvl & ~prev_q;

    led_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run),
        .clr (mode_adv),
        .tick(tick)
    );

    mode_t            mode_q, mode_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] shl, shr, rol, ror;
    logic             step_q, step_d;
    logic             up_q, up_d;

    assign shl = led_q << 1;
    assign shr = led_q >> 1;
    assign rol = shl | (led_q >> (LED_W - 1));
    assign ror = shr | (led_q << (LED_W - 1));

    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        up_d   = up_q;
        step_d = 1'b0;
        if (mode_adv) begin
            mode_d = mode_t'(mode_q + 2'd1);
            led_d  = LED_W'(seed_lsb(mode_d));
            up_d   = 1'b1;
        end else if (tick) begin
            step_d = 1'b1;
            unique case (mode_q)
                MODE_COUNT: led_d = dir ? led_q + ONE : led_q - ONE;
                MODE_SHIFT: led_d = dir ? rol : ror;
                MODE_SCAN: begin
                    // Bounce reverses on the same step it hits an end bit.
                    if (LED_W == 1) begin
                        led_d = ONE;
                    end else if (up_q) begin
                        up_d  = ~led_q[LED_W-1];
                        led_d = led_q[LED_W-1] ? shr : shl;
                    end else begin
                        up_d  = led_q[0];
                        led_d = led_q[0] ? shl : shr;
                    end
                end
                MODE_FILL: begin
                    if (&led_q) begin
                        led_d = '0;
                    end else begin
                        led_d = dir ? (shl | ONE) : (shr | MSB);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_COUNT;
            led_q  <= '0;
            step_q <= 1'b0;
            up_q   <= 1'b1;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            step_q <= step_d;
            up_q   <= up_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule
